// File: rtl/pc_flow_ctrl_if.sv
// Decode-to-PC control-flow bundle: op handshake from decode, redirect controls toward the PC.
interface pc_flow_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_type;
    logic [15:0] op_target;
    logic [15:0] pc_cur;
    logic        zero_flag;
    logic        jump;
    logic        branch;
    logic        call;
    logic        ret;
    logic [15:0] target_addr;
    logic [15:0] ret_addr;
    logic        flush;

    modport master (
        output op_valid, op_type, op_target, pc_cur, zero_flag,
        input  op_ready, jump, branch, call, ret, target_addr, ret_addr, flush
    );

    modport slave (
        input  op_valid, op_type, op_target, pc_cur, zero_flag,
        output op_ready, jump, branch, call, ret, target_addr, ret_addr, flush
    );
endinterface

// File: rtl/pc_flow_ctrl.sv
// Control-flow sequencer with return-address stack and post-redirect flush window.
// Define PCCTRL_RAS_WRAP_EN to make the RAS circular (CALL on full overwrites the oldest entry).
module pc_flow_ctrl #(
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    pc_flow_ctrl_if.slave              bus,
    input  logic                       err_clr_i,
    output logic [$clog2(DEPTH):0]     ras_count_o,
    output logic                       err_ovf_o,
    output logic                       err_unf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] FC_INIT = 4'(FLUSH_CYCLES - 1);

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRZ  = 3'd2;
    localparam logic [2:0] OP_BRNZ = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    // state     | meaning
    // IDLE      | ready for an op
    // POP       | reading top of RAS
    // RET_ISSUE | loading ret pulse and popped address
    // FLUSH     | flush held, front end stalled
    typedef enum logic [1:0] {S_IDLE, S_POP, S_RET_ISSUE, S_FLUSH} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          op_ready_q;
    logic          jump_q, jump_d;
    logic          branch_q, branch_d;
    logic          call_q, call_d;
    logic          ret_q, ret_d;
    logic [15:0]   target_q, target_d;
    logic [15:0]   ret_addr_q, ret_addr_d;
    logic [15:0]   pop_data_q;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;
    logic [15:0]   ras_mem_q [DEPTH];

    logic          accept;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_unf;
    logic [15:0]   push_val;

    assign accept   = bus.op_valid && op_ready_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_val = bus.pc_cur + 16'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        jump_d     = 1'b0;
        branch_d   = 1'b0;
        call_d     = 1'b0;
        ret_d      = 1'b0;
        target_d   = target_q;
        ret_addr_d = ret_addr_q;
        push       = 1'b0;
        pop        = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.op_type)
                        OP_JMP: begin
                            jump_d   = 1'b1;
                            target_d = bus.op_target;
                            state_d  = S_FLUSH;
                            cnt_d    = FC_INIT;
                        end
                        OP_BRZ, OP_BRNZ: begin
                            if (bus.zero_flag == (bus.op_type == OP_BRZ)) begin
                                branch_d = 1'b1;
                                target_d = bus.op_target;
                                state_d  = S_FLUSH;
                                cnt_d    = FC_INIT;
                            end
                        end
                        OP_CALL: begin
                            if (full) begin
                                set_ovf = 1'b1;
                            end
`ifdef PCCTRL_RAS_WRAP_EN
                            if (1'b1) begin
`else
                            if (!full) begin
`endif
                                push     = 1'b1;
                                call_d   = 1'b1;
                                jump_d   = 1'b1;
                                target_d = bus.op_target;
                                state_d  = S_FLUSH;
                                cnt_d    = FC_INIT;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                set_unf = 1'b1;
                            end else begin
                                pop     = 1'b1;
                                state_d = S_POP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_POP: begin
                state_d = S_RET_ISSUE;
            end
            S_RET_ISSUE: begin
                ret_d      = 1'b1;
                ret_addr_d = pop_data_q;
                state_d    = S_FLUSH;
                cnt_d      = FC_INIT;
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointer always addresses the next free slot; when full it aliases the oldest entry.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            ptr_d   = ptr_q + PW'(1);
            count_d = full ? count_q : count_q + CW'(1);
        end else if (pop) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        if (err_clr_i) begin
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end
        if (set_ovf) err_ovf_d = 1'b1;
        if (set_unf) err_unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            op_ready_q <= 1'b0;
            jump_q     <= 1'b0;
            branch_q   <= 1'b0;
            call_q     <= 1'b0;
            ret_q      <= 1'b0;
            target_q   <= '0;
            ret_addr_q <= '0;
            pop_data_q <= '0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            op_ready_q <= (state_d == S_IDLE);
            jump_q     <= jump_d;
            branch_q   <= branch_d;
            call_q     <= call_d;
            ret_q      <= ret_d;
            target_q   <= target_d;
            ret_addr_q <= ret_addr_d;
            if (state_q == S_POP) begin
                pop_data_q <= ras_mem_q[ptr_q];
            end
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem_q[ptr_q] <= push_val;
        end
    end

    assign bus.op_ready    = op_ready_q;
    assign bus.jump        = jump_q;
    assign bus.branch      = branch_q;
    assign bus.call        = call_q;
    assign bus.ret         = ret_q;
    assign bus.target_addr = target_q;
    assign bus.ret_addr    = ret_addr_q;
    assign bus.flush       = (state_q == S_FLUSH);
    assign ras_count_o     = count_q;
    assign err_ovf_o       = err_ovf_q;
    assign err_unf_o       = err_unf_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl: redirects, RAS push/pop, error flags, overflow and reset abort.
module tb_pc_flow_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] ras_count;
    logic       err_ovf;
    logic       err_unf;

    int pass_cnt = 0;
    int total_cnt = 0;

    pc_flow_ctrl_if bus();

    pc_flow_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .err_clr_i   (err_clr),
        .ras_count_o (ras_count),
        .err_ovf_o   (err_ovf),
        .err_unf_o   (err_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic [15:0] tgt, input logic [15:0] pc, input logic z);
        bus.op_valid  = 1'b1;
        bus.op_type   = t;
        bus.op_target = tgt;
        bus.pc_cur    = pc;
        bus.zero_flag = z;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.op_valid = 1'b0; bus.op_type = 3'd0; bus.op_target = '0; bus.pc_cur = '0; bus.zero_flag = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({bus.op_ready, bus.jump, bus.branch, bus.call, bus.ret, bus.flush} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {bus.op_ready, bus.jump, bus.branch, bus.call, bus.ret, bus.flush});
        else pass_cnt++;
        total_cnt++;
        if ({ras_count, err_ovf, err_unf, bus.target_addr, bus.ret_addr} !== '0) $display("FAIL reset_state: cnt %0d ovf %b unf %b tgt %h ret %h want all 0", ras_count, err_ovf, err_unf, bus.target_addr, bus.ret_addr);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if (bus.op_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.op_ready);
        else pass_cnt++;
    endtask

    task automatic test_jmp();
        drive(3'd1, 16'h1234, 16'h0010, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        total_cnt++;
        if ({bus.jump, bus.branch, bus.call, bus.ret, bus.flush, bus.op_ready} !== 6'b100010) $display("FAIL jmp_pulse: got %b want 100010", {bus.jump, bus.branch, bus.call, bus.ret, bus.flush, bus.op_ready});
        else pass_cnt++;
        total_cnt++;
        if (bus.target_addr !== 16'h1234) $display("FAIL jmp_target: got %h want 1234", bus.target_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.jump, bus.flush, bus.op_ready} !== 3'b010) $display("FAIL jmp_flush2: got %b want 010", {bus.jump, bus.flush, bus.op_ready});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.flush, bus.op_ready} !== 2'b01) $display("FAIL jmp_done: got %b want 01", {bus.flush, bus.op_ready});
        else pass_cnt++;
    endtask

    task automatic test_branch();
        drive(3'd2, 16'h0040, 16'h0020, 1'b1);
        tick();
        bus.op_valid = 1'b0;
        total_cnt++;
        if ({bus.branch, bus.jump, bus.flush, bus.target_addr} !== {3'b101, 16'h0040}) $display("FAIL brz_taken: got br %b jmp %b fl %b tgt %h want 1 0 1 0040", bus.branch, bus.jump, bus.flush, bus.target_addr);
        else pass_cnt++;
        tick(); tick();
        drive(3'd2, 16'h0040, 16'h0021, 1'b0);
        tick();
        total_cnt++;
        if ({bus.branch, bus.jump, bus.flush, bus.op_ready} !== 4'b0001) $display("FAIL brz_not_taken: got %b want 0001", {bus.branch, bus.jump, bus.flush, bus.op_ready});
        else pass_cnt++;
        drive(3'd3, 16'h0050, 16'h0022, 1'b1);
        tick();
        total_cnt++;
        if ({bus.branch, bus.jump, bus.flush, bus.op_ready} !== 4'b0001) $display("FAIL brnz_not_taken: got %b want 0001", {bus.branch, bus.jump, bus.flush, bus.op_ready});
        else pass_cnt++;
        drive(3'd3, 16'h0060, 16'h0023, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        total_cnt++;
        if ({bus.branch, bus.target_addr} !== {1'b1, 16'h0060}) $display("FAIL brnz_taken: got br %b tgt %h want 1 0060", bus.branch, bus.target_addr);
        else pass_cnt++;
        tick(); tick();
        drive(3'd7, 16'h0070, 16'h0024, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        total_cnt++;
        if ({bus.jump, bus.branch, bus.call, bus.ret, bus.flush, bus.op_ready} !== 6'b000001) $display("FAIL op7_nop: got %b want 000001", {bus.jump, bus.branch, bus.call, bus.ret, bus.flush, bus.op_ready});
        else pass_cnt++;
    endtask

    task automatic test_call_ret(input logic [15:0] pc, input logic [15:0] exp_ret);
        drive(3'd4, 16'h0800, pc, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        total_cnt++;
        if ({bus.call, bus.jump, bus.flush, bus.target_addr, ras_count} !== {3'b111, 16'h0800, 4'd1}) $display("FAIL call_pulse: got call %b jmp %b fl %b tgt %h cnt %0d want 1 1 1 0800 1", bus.call, bus.jump, bus.flush, bus.target_addr, ras_count);
        else pass_cnt++;
        tick(); tick();
        drive(3'd5, 16'h0000, 16'h0900, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        total_cnt++;
        if ({ras_count, bus.ret, bus.op_ready} !== {4'd0, 2'b00}) $display("FAIL ret_pop: got cnt %0d ret %b rdy %b want 0 0 0", ras_count, bus.ret, bus.op_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.ret !== 1'b0) $display("FAIL ret_early: got %b want 0", bus.ret);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.ret, bus.jump, bus.branch, bus.flush, bus.ret_addr} !== {4'b1001, exp_ret}) $display("FAIL ret_pulse: got ret %b jmp %b br %b fl %b addr %h want 1 0 0 1 %h", bus.ret, bus.jump, bus.branch, bus.flush, bus.ret_addr, exp_ret);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.ret, bus.flush} !== 2'b01) $display("FAIL ret_after: got %b want 01", {bus.ret, bus.flush});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.op_ready !== 1'b1) $display("FAIL ret_ready: got %b want 1", bus.op_ready);
        else pass_cnt++;
    endtask

    task automatic test_underflow();
        drive(3'd5, 16'h0000, 16'h0300, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        total_cnt++;
        if ({err_unf, bus.ret, bus.flush, bus.op_ready, ras_count} !== {4'b1001, 4'd0}) $display("FAIL unf_set: got unf %b ret %b fl %b rdy %b cnt %0d want 1 0 0 1 0", err_unf, bus.ret, bus.flush, bus.op_ready, ras_count);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if ({bus.ret, err_unf} !== 2'b01) $display("FAIL unf_nopulse: got %b want 01", {bus.ret, err_unf});
        else pass_cnt++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total_cnt++;
        if (err_unf !== 1'b0) $display("FAIL unf_clr: got %b want 0", err_unf);
        else pass_cnt++;
        err_clr = 1'b1;
        drive(3'd5, 16'h0000, 16'h0301, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        err_clr = 1'b0;
        total_cnt++;
        if (err_unf !== 1'b1) $display("FAIL unf_set_wins: got %b want 1", err_unf);
        else pass_cnt++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            drive(3'd4, 16'h2000 + 16'(i), 16'h1000 + 16'(i), 1'b0);
            tick();
            bus.op_valid = 1'b0;
            total_cnt++;
            if ({bus.call, bus.jump} !== 2'b11) $display("FAIL ovf_fill_%0d: got %b want 11", i, {bus.call, bus.jump});
            else pass_cnt++;
            tick(); tick();
        end
        total_cnt++;
        if (ras_count !== 4'(DEPTH)) $display("FAIL ovf_full_cnt: got %0d want %0d", ras_count, DEPTH);
        else pass_cnt++;
        drive(3'd4, 16'h2008, 16'h1008, 1'b0);
        tick();
        bus.op_valid = 1'b0;
`ifdef PCCTRL_RAS_WRAP_EN
        total_cnt++;
        if ({bus.call, bus.jump, bus.flush, err_ovf, ras_count} !== {4'b1111, 4'(DEPTH)}) $display("FAIL ovf_wrap_call: got call %b jmp %b fl %b ovf %b cnt %0d want 1 1 1 1 %0d", bus.call, bus.jump, bus.flush, err_ovf, ras_count, DEPTH);
        else pass_cnt++;
        tick(); tick();
`else
        total_cnt++;
        if ({bus.call, bus.jump, bus.flush, bus.op_ready, err_ovf, ras_count} !== {5'b00011, 4'(DEPTH)}) $display("FAIL ovf_reject: got call %b jmp %b fl %b rdy %b ovf %b cnt %0d want 0 0 0 1 1 %0d", bus.call, bus.jump, bus.flush, bus.op_ready, err_ovf, ras_count, DEPTH);
        else pass_cnt++;
        tick();
`endif
        for (int i = 0; i < DEPTH; i++) begin
`ifdef PCCTRL_RAS_WRAP_EN
            exp = 16'h1009 - 16'(i);
`else
            exp = 16'h1008 - 16'(i);
`endif
            drive(3'd5, 16'h0000, 16'h0400, 1'b0);
            tick();
            bus.op_valid = 1'b0;
            tick(); tick();
            total_cnt++;
            if ({bus.ret, bus.ret_addr} !== {1'b1, exp}) $display("FAIL ovf_ret_%0d: got ret %b addr %h want 1 %h", i, bus.ret, bus.ret_addr, exp);
            else pass_cnt++;
            tick(); tick();
        end
        total_cnt++;
        if (ras_count !== 4'd0) $display("FAIL ovf_drain_cnt: got %0d want 0", ras_count);
        else pass_cnt++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total_cnt++;
        if (err_ovf !== 1'b0) $display("FAIL ovf_clr: got %b want 0", err_ovf);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_pop();
        logic seen;
        for (int i = 0; i < 2; i++) begin
            drive(3'd4, 16'h0a00, 16'h0200 + 16'(i), 1'b0);
            tick();
            bus.op_valid = 1'b0;
            tick(); tick();
        end
        drive(3'd5, 16'h0000, 16'h0500, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        total_cnt++;
        if (ras_count !== 4'd1) $display("FAIL rst_pop_cnt: got %0d want 1", ras_count);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.op_ready, bus.jump, bus.branch, bus.call, bus.ret, bus.flush, ras_count, bus.target_addr} !== '0) $display("FAIL rst_mid_outputs: got rdy %b jmp %b br %b call %b ret %b fl %b cnt %0d tgt %h want all 0", bus.op_ready, bus.jump, bus.branch, bus.call, bus.ret, bus.flush, ras_count, bus.target_addr);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ret || bus.jump || bus.flush) seen = 1'b1;
        end
        total_cnt++;
        if ({seen, bus.op_ready} !== 2'b01) $display("FAIL rst_no_ret: got pulse_seen %b rdy %b want 0 1", seen, bus.op_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_branch();
        test_call_ret(16'h0100, 16'h0101);
        test_call_ret(16'hFFFF, 16'h0000);
        test_underflow();
        test_overflow();
        test_reset_mid_pop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
